// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector for DWELL cycles,
// samples dut_z in the last dwell cycle and scores it against a latched table.
module tt_sweep_checker #(
    parameter int N_IN  = 4,
    parameter int DWELL = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [(1<<N_IN)-1:0] exp_tt,
    output logic [N_IN-1:0]      vec,
    input  logic                 dut_z,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 first_err_valid,
    output logic [1:0]           dbg_state
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Handshake: start is a level sampled on the clock edge; it is accepted only
    // in IDLE, busy is high for the whole sweep and done is a one-cycle strobe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [CW-1:0]       dwell_q, dwell_d;
    logic [NV-1:0]       tt_q, tt_d;
    logic [N_IN:0]       err_q, err_d;
    logic [N_IN-1:0]     first_idx_q, first_idx_d;
    logic                first_valid_q, first_valid_d;
    logic                pass_q, pass_d;
    logic                sample;
    logic                mismatch;

    assign sample   = (dwell_q == CW'(DWELL - 1));
    assign mismatch = (dut_z != tt_q[vec_q]);

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        dwell_d       = dwell_q;
        tt_d          = tt_q;
        err_d         = err_q;
        first_idx_d   = first_idx_q;
        first_valid_d = first_valid_q;
        pass_d        = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d          = exp_tt;
                    vec_d         = '0;
                    dwell_d       = '0;
                    err_d         = '0;
                    first_idx_d   = '0;
                    first_valid_d = 1'b0;
                    pass_d        = 1'b0;
                    state_d       = RUN;
                end
            end
            RUN: begin
                dwell_d = dwell_q + CW'(1);
                if (sample) begin
                    dwell_d = '0;
                    if (mismatch) begin
                        err_d = err_q + (N_IN + 1)'(1);
                        if (!first_valid_q) begin
                            first_idx_d   = vec_q;
                            first_valid_d = 1'b1;
                        end
                    end
                    // pass is resolved here so the final sample is included.
                    if (vec_q == N_IN'(NV - 1)) begin
                        vec_d   = '0;
                        pass_d  = (err_d == '0);
                        state_d = FIN;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            dwell_q       <= '0;
            tt_q          <= '0;
            err_q         <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            dwell_q       <= dwell_d;
            tt_q          <= tt_d;
            err_q         <= err_d;
            first_idx_q   <= first_idx_d;
            first_valid_q <= first_valid_d;
            pass_q        <= pass_d;
        end
    end

    assign vec             = vec_q;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == FIN);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = first_idx_q;
    assign first_err_valid = first_valid_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a 4-input/DWELL=20 instance against a
// behavioural DUT with fault injection, and a 2-input/DWELL=1 XOR instance.
module tb_tt_sweep_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  // 4-input, DWELL=20 instance
  logic        start = 1'b0;
  logic [15:0] exp_tt = 16'hA5C3;
  logic [3:0]  vec;
  logic        dut_z;
  logic        busy, done, pass, first_err_valid;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic [1:0]  dbg_state;

  // 2-input, DWELL=1 instance
  logic        start2 = 1'b0;
  logic [3:0]  exp_tt2 = 4'b0110;
  logic [1:0]  vec2;
  logic        dut_z2;
  logic        busy2, done2, pass2, first_err_valid2;
  logic [2:0]  err_count2;
  logic [1:0]  first_err_idx2;
  logic [1:0]  dbg_state2;

  // Behavioural DUT: reference table, per-vector inversion mask, dwell glitch.
  logic [15:0] model_tt = 16'hA5C3;
  logic [15:0] inv_mask = 16'h0000;
  logic        glitch_en = 1'b0;
  int          cyc = 0;
  int          c0 = 0;
  int          n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dut_z  = model_tt[vec] ^ inv_mask[vec] ^ (glitch_en && (((cyc - c0) % 20) != 19));
  assign dut_z2 = ^vec2;

  tt_sweep_checker #(.N_IN(4), .DWELL(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tt(exp_tt), .vec(vec),
    .dut_z(dut_z), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid), .dbg_state(dbg_state)
  );

  tt_sweep_checker #(.N_IN(2), .DWELL(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .exp_tt(exp_tt2), .vec(vec2),
    .dut_z(dut_z2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_idx(first_err_idx2), .first_err_valid(first_err_valid2), .dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pulse start for one edge; returns at the negedge just after the accepting edge.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
  endtask

  // Counts negedges until done is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fidx", first_err_idx, 0);
    check("rst_fval", first_err_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_vec2", vec2, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep: vec steps every 20 cycles, done 320 cycles after start
    do_start();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t1_vec%0d", k), vec, k);
      check($sformatf("t1_busy%0d", k), busy, 1);
      repeat (20) @(negedge clk);
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_vec_end", vec, 0);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_fval", first_err_valid, 0);
    @(negedge clk);
    check("t1_done_width", done, 0);
    check("t1_pass_hold", pass, 1);

    // Faults at vectors 9 and 12
    inv_mask = 16'h1200;
    do_start();
    wait_done(n);
    check("t2_latency", n, 320);
    check("t2_err", err_count, 2);
    check("t2_fidx", first_err_idx, 9);
    check("t2_fval", first_err_valid, 1);
    check("t2_pass", pass, 0);
    @(negedge clk);
    check("t2_err_hold", err_count, 2);

    // Fully inverted DUT
    inv_mask = 16'hFFFF;
    do_start();
    wait_done(n);
    check("t3_latency", n, 320);
    check("t3_err", err_count, 5'b10000);
    check("t3_fidx", first_err_idx, 0);
    check("t3_fval", first_err_valid, 1);
    check("t3_pass", pass, 0);

    // Wrong in dwell cycles 0..18, correct in 19
    inv_mask = 16'h0000;
    glitch_en = 1'b1;
    do_start();
    wait_done(n);
    check("t4_latency", n, 320);
    check("t4_pass", pass, 1);
    check("t4_err", err_count, 0);
    glitch_en = 1'b0;

    // start re-pulsed at cycle 100, exp_tt cleared at cycle 150
    do_start();
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    exp_tt = 16'h0000;
    wait_done(n);
    check("t5_latency", n, 171);
    check("t5_pass", pass, 1);
    check("t5_err", err_count, 0);
    @(negedge clk);
    check("t5_single_done", done, 0);
    exp_tt = 16'hA5C3;

    // Reset during vector 5 of a run that already has one mismatch
    inv_mask = 16'h0004;
    do_start();
    repeat (104) @(negedge clk);
    check("t6_vec5", vec, 5);
    check("t6_err_pre", err_count, 1);
    rst_n = 1'b0;
    #1;
    check("t6_vec", vec, 0);
    check("t6_busy", busy, 0);
    check("t6_err", err_count, 0);
    check("t6_fval", first_err_valid, 0);
    check("t6_fidx", first_err_idx, 0);
    check("t6_state", dbg_state, 0);
    @(negedge clk);
    check("t6_no_done", done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_done", done, 0);
    inv_mask = 16'h0000;
    do_start();
    wait_done(n);
    check("t6_fresh_latency", n, 320);
    check("t6_fresh_pass", pass, 1);

    // start held high: next sweep begins on the first IDLE cycle
    repeat (2) @(negedge clk);
    start = 1'b1;
    wait_done(n);
    check("t7_latency", n, 321);
    @(negedge clk);
    check("t7_fin_idle_busy", busy, 0);
    check("t7_fin_idle_done", done, 0);
    @(negedge clk);
    check("t7_restart_busy", busy, 1);
    start = 1'b0;
    wait_done(n);
    check("t7_second_latency", n, 320);
    check("t7_second_pass", pass, 1);

    // 2-input XOR, DWELL=1
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t8_vec%0d", k), vec2, k);
      check($sformatf("t8_done_early%0d", k), done2, 0);
      @(negedge clk);
    end
    check("t8_done", done2, 1);
    check("t8_pass", pass2, 1);
    check("t8_err", err_count2, 0);
    check("t8_busy_end", busy2, 0);
    @(negedge clk);
    check("t8_done_width", done2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
